// File: rtl/oflow_core_set_scheduler_if.sv
// ---------------------------------------------------------------------------
// oflow_core_set_scheduler_if
//
// Bundles every handshake and bus signal of the oflow core set scheduler so
// the scheduler, the core top-level controller, the bbox loader and the PE
// array can be connected through a single port.
//
// Signal groups:
//   frame control : start_frame, num_of_bboxes   (controller -> scheduler)
//                   frame_busy, frame_done       (scheduler  -> controller)
//   set load      : load_req                     (scheduler  -> loader)
//                   load_ack                     (loader     -> scheduler)
//   FE stage      : set_idx_fe, mask_fe, start_fe  (scheduler -> PE array)
//                   done_fe                        (PE array  -> scheduler)
//   REG stage     : set_idx_reg, mask_reg, start_reg (scheduler -> PE array)
//                   done_reg                         (PE array  -> scheduler)
//
// Modports:
//   master : the scheduler side
//   slave  : the controller / loader / PE-array side
// ---------------------------------------------------------------------------
interface oflow_core_set_scheduler_if #(
    parameter int PE_NUM = 24,
    parameter int BBOX_W = 8,
    parameter int SET_W  = 4
) ();

    // Frame control
    logic              start_frame;
    logic [BBOX_W-1:0] num_of_bboxes;
    logic              frame_busy;
    logic              frame_done;

    // Set load handshake
    logic              load_req;
    logic              load_ack;

    // Feature-extraction stage
    logic [SET_W-1:0]  set_idx_fe;
    logic [PE_NUM-1:0] mask_fe;
    logic [PE_NUM-1:0] start_fe;
    logic [PE_NUM-1:0] done_fe;

    // Registration stage
    logic [SET_W-1:0]  set_idx_reg;
    logic [PE_NUM-1:0] mask_reg;
    logic [PE_NUM-1:0] start_reg;
    logic [PE_NUM-1:0] done_reg;

    modport master (
        input  start_frame,
        input  num_of_bboxes,
        output frame_busy,
        output frame_done,
        output load_req,
        input  load_ack,
        output set_idx_fe,
        output mask_fe,
        output start_fe,
        input  done_fe,
        output set_idx_reg,
        output mask_reg,
        output start_reg,
        input  done_reg
    );

    modport slave (
        output start_frame,
        output num_of_bboxes,
        input  frame_busy,
        input  frame_done,
        input  load_req,
        output load_ack,
        input  set_idx_fe,
        input  mask_fe,
        input  start_fe,
        output done_fe,
        input  set_idx_reg,
        input  mask_reg,
        input  start_reg,
        output done_reg
    );

endinterface

// File: rtl/oflow_core_set_scheduler.sv
// ---------------------------------------------------------------------------
// oflow_core_set_scheduler
//
// Frame-level set scheduler for the oflow core PE array. A frame of n bboxes
// is split into ceil(n/PE_NUM) sets; each set is loaded into the PEs, run
// through feature extraction (FE) and then through registration (REG). FE of
// set k+1 (including its load) overlaps registration of set k; one finished
// FE set can be parked in FE_HOLD while registration is still busy.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high; clears all state and outputs
//   sched_if  master modport of oflow_core_set_scheduler_if:
//     start_frame / num_of_bboxes  frame request and its bbox count
//     frame_busy / frame_done      frame in progress / last set registered
//     load_req / load_ack          level request / one-cycle ack for set load
//     set_idx_fe, mask_fe          set currently loading or in FE, its PE mask
//     start_fe / done_fe           one-cycle FE start (= mask_fe) / per-PE done
//     set_idx_reg, mask_reg        set currently in registration, its PE mask
//     start_reg / done_reg         one-cycle REG start (= mask_reg) / per-PE done
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module oflow_core_set_scheduler #(
    parameter int PE_NUM = 24,
    parameter int BBOX_W = 8,
    parameter int SET_W  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    oflow_core_set_scheduler_if.master  sched_if
);

    typedef enum logic [1:0] {
        FE_IDLE,
        FE_LOAD,
        FE_RUN,
        FE_HOLD
    } fe_state_t;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } reg_state_t;

    // Active-PE mask of set s in a frame of n bboxes: the low
    // min(n - s*PE_NUM, PE_NUM) bits are set. The subtraction saturates at
    // zero so a set index past the end yields an empty mask instead of a wrap.
    function automatic logic [PE_NUM-1:0] set_mask(
        input logic [BBOX_W-1:0] n,
        input logic [SET_W-1:0]  s
    );
        logic [31:0]       base;
        logic [31:0]       rem;
        logic [PE_NUM-1:0] m;
        base = 32'(s) * 32'(PE_NUM);
        rem  = (32'(n) > base) ? (32'(n) - base) : 32'd0;
        m    = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            m[i] = (32'(i) < rem);
        end
        return m;
    endfunction

    // Index of the final set, ceil(n/PE_NUM) - 1. Only meaningful for n > 0;
    // an empty frame never reaches a stage that compares against it.
    function automatic logic [SET_W-1:0] last_set_of(input logic [BBOX_W-1:0] n);
        logic [31:0] sets;
        sets = (32'(n) + 32'(PE_NUM) - 32'd1) / 32'(PE_NUM);
        return SET_W'(sets - 32'd1);
    endfunction

    // Frame bookkeeping
    logic [BBOX_W-1:0] n_q,          n_d;
    logic [SET_W-1:0]  last_set_q,   last_set_d;
    logic              frame_busy_q, frame_busy_d;
    logic              frame_done_q, frame_done_d;

    // FE stage
    fe_state_t         fe_state_q,   fe_state_d;
    logic              load_req_q,   load_req_d;
    logic [SET_W-1:0]  set_idx_fe_q, set_idx_fe_d;
    logic [PE_NUM-1:0] mask_fe_q,    mask_fe_d;
    logic [PE_NUM-1:0] start_fe_q,   start_fe_d;
    logic [PE_NUM-1:0] fe_sticky_q,  fe_sticky_d;

    // REG stage
    reg_state_t        reg_state_q,   reg_state_d;
    logic [SET_W-1:0]  set_idx_reg_q, set_idx_reg_d;
    logic [PE_NUM-1:0] mask_reg_q,    mask_reg_d;
    logic [PE_NUM-1:0] start_reg_q,   start_reg_d;
    logic [PE_NUM-1:0] reg_sticky_q,  reg_sticky_d;

    // Completion detection. The start pulse register is non-zero exactly in
    // the first RUN cycle of a stage (masks of a running set are never empty),
    // so it doubles as the "ignore dones this cycle" flag. The current cycle's
    // done bits are folded in so completion is seen in the cycle they arrive.
    logic fe_first;
    logic reg_first;
    logic fe_all_done;
    logic reg_all_done;

    assign fe_first     = |start_fe_q;
    assign reg_first    = |start_reg_q;
    assign fe_all_done  = !fe_first &&
                          (((fe_sticky_q | sched_if.done_fe) & mask_fe_q) == mask_fe_q);
    assign reg_all_done = !reg_first &&
                          (((reg_sticky_q | sched_if.done_reg) & mask_reg_q) == mask_reg_q);

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        n_d           = n_q;
        last_set_d    = last_set_q;
        frame_busy_d  = frame_busy_q;
        frame_done_d  = 1'b0;
        fe_state_d    = fe_state_q;
        load_req_d    = load_req_q;
        set_idx_fe_d  = set_idx_fe_q;
        mask_fe_d     = mask_fe_q;
        start_fe_d    = '0;
        fe_sticky_d   = fe_sticky_q;
        reg_state_d   = reg_state_q;
        set_idx_reg_d = set_idx_reg_q;
        mask_reg_d    = mask_reg_q;
        start_reg_d   = '0;
        reg_sticky_d  = reg_sticky_q;

        // Frame accept. Both stages are idle whenever frame_busy is low, so
        // the FSM cases below have nothing to do in the same cycle.
        if (sched_if.start_frame && !frame_busy_q) begin
            n_d          = sched_if.num_of_bboxes;
            last_set_d   = last_set_of(sched_if.num_of_bboxes);
            set_idx_fe_d = '0;
            mask_fe_d    = set_mask(sched_if.num_of_bboxes, '0);
            if (sched_if.num_of_bboxes == '0) begin
                // Empty frame: nothing to load or start, report done at once.
                frame_done_d = 1'b1;
            end else begin
                frame_busy_d = 1'b1;
                load_req_d   = 1'b1;
                fe_state_d   = FE_LOAD;
            end
        end

        // FE stage: load, run, then park until registration can take the set.
        case (fe_state_q)
            FE_LOAD: begin
                if (sched_if.load_ack) begin
                    load_req_d  = 1'b0;
                    start_fe_d  = mask_fe_q;
                    fe_sticky_d = '0;
                    fe_state_d  = FE_RUN;
                end
            end
            FE_RUN: begin
                if (fe_first) begin
                    fe_sticky_d = '0;
                end else begin
                    fe_sticky_d = fe_sticky_q | (sched_if.done_fe & mask_fe_q);
                    if (fe_all_done) begin
                        fe_state_d = FE_HOLD;
                    end
                end
            end
            FE_HOLD: begin
                if (reg_state_q == R_IDLE) begin
                    if (set_idx_fe_q == last_set_q) begin
                        fe_state_d = FE_IDLE;
                    end else begin
                        set_idx_fe_d = set_idx_fe_q + SET_W'(1);
                        mask_fe_d    = set_mask(n_q, set_idx_fe_q + SET_W'(1));
                        load_req_d   = 1'b1;
                        fe_state_d   = FE_LOAD;
                    end
                end
            end
            default: ;
        endcase

        // REG stage: takes the parked FE set, runs it, signals frame end.
        case (reg_state_q)
            R_IDLE: begin
                if (fe_state_q == FE_HOLD) begin
                    set_idx_reg_d = set_idx_fe_q;
                    mask_reg_d    = mask_fe_q;
                    start_reg_d   = mask_fe_q;
                    reg_sticky_d  = '0;
                    reg_state_d   = R_RUN;
                end
            end
            R_RUN: begin
                if (reg_first) begin
                    reg_sticky_d = '0;
                end else begin
                    reg_sticky_d = reg_sticky_q | (sched_if.done_reg & mask_reg_q);
                    if (reg_all_done) begin
                        reg_state_d = R_IDLE;
                        if (set_idx_reg_q == last_set_q) begin
                            frame_done_d = 1'b1;
                            frame_busy_d = 1'b0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q           <= '0;
            last_set_q    <= '0;
            frame_busy_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            fe_state_q    <= FE_IDLE;
            load_req_q    <= 1'b0;
            set_idx_fe_q  <= '0;
            mask_fe_q     <= '0;
            start_fe_q    <= '0;
            fe_sticky_q   <= '0;
            reg_state_q   <= R_IDLE;
            set_idx_reg_q <= '0;
            mask_reg_q    <= '0;
            start_reg_q   <= '0;
            reg_sticky_q  <= '0;
        end else begin
            n_q           <= n_d;
            last_set_q    <= last_set_d;
            frame_busy_q  <= frame_busy_d;
            frame_done_q  <= frame_done_d;
            fe_state_q    <= fe_state_d;
            load_req_q    <= load_req_d;
            set_idx_fe_q  <= set_idx_fe_d;
            mask_fe_q     <= mask_fe_d;
            start_fe_q    <= start_fe_d;
            fe_sticky_q   <= fe_sticky_d;
            reg_state_q   <= reg_state_d;
            set_idx_reg_q <= set_idx_reg_d;
            mask_reg_q    <= mask_reg_d;
            start_reg_q   <= start_reg_d;
            reg_sticky_q  <= reg_sticky_d;
        end
    end

    assign sched_if.frame_busy  = frame_busy_q;
    assign sched_if.frame_done  = frame_done_q;
    assign sched_if.load_req    = load_req_q;
    assign sched_if.set_idx_fe  = set_idx_fe_q;
    assign sched_if.mask_fe     = mask_fe_q;
    assign sched_if.start_fe    = start_fe_q;
    assign sched_if.set_idx_reg = set_idx_reg_q;
    assign sched_if.mask_reg    = mask_reg_q;
    assign sched_if.start_reg   = start_reg_q;

endmodule

// File: tb/tb_oflow_core_set_scheduler.sv
// ---------------------------------------------------------------------------
// tb_oflow_core_set_scheduler
//
// Directed bench for the set scheduler. A responder process plays loader and
// PE array (immediate acks, dones one cycle after each start, optional REG
// delay for set 0, optional one-PE-per-cycle FE dones and forced spurious
// bits). A monitor logs every start pulse, load request and frame_done with
// its cycle number; the main process compares those logs to hand-computed
// sequences and cycle offsets.
// ---------------------------------------------------------------------------
module tb_oflow_core_set_scheduler;

    localparam int PE_NUM    = 24;
    localparam int BBOX_W    = 8;
    localparam int SET_W     = 4;
    localparam int FULL_MASK = 32'h00FF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oflow_core_set_scheduler_if #(.PE_NUM(PE_NUM), .BBOX_W(BBOX_W), .SET_W(SET_W)) sif ();

    oflow_core_set_scheduler #(.PE_NUM(PE_NUM), .BBOX_W(BBOX_W), .SET_W(SET_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .sched_if (sif.master)
    );

    // ------------------------------------------------------------------ check
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // -------------------------------------------------------------- responder
    int                fe_stagger_set = -1;     // set whose FE dones arrive one PE per cycle
    logic [PE_NUM-1:0] fe_force       = '0;     // done_fe bits held high the whole time
    int                reg_delay0     = 1;      // cycles from start_reg to done_reg for set 0

    logic [PE_NUM-1:0] fe_pend;
    logic              fe_pend_v;
    logic [PE_NUM-1:0] reg_pend;
    int                reg_cnt;
    logic              stag_v;
    int                stag_bit;
    int                stag_len;

    initial begin
        sif.load_ack = 1'b0;
        sif.done_fe  = '0;
        sif.done_reg = '0;
        fe_pend      = '0;
        fe_pend_v    = 1'b0;
        reg_pend     = '0;
        reg_cnt      = 0;
        stag_v       = 1'b0;
        stag_bit     = 0;
        stag_len     = 0;
        forever begin
            @(negedge clk);
            sif.done_fe  = '0;
            sif.done_reg = '0;
            if (reset) begin
                sif.load_ack = 1'b0;
                fe_pend_v    = 1'b0;
                reg_cnt      = 0;
                stag_v       = 1'b0;
            end else begin
                sif.load_ack = sif.load_req && !sif.load_ack;
                sif.done_fe  = fe_force;
                if (fe_pend_v) begin
                    sif.done_fe = sif.done_fe | fe_pend;
                    fe_pend_v   = 1'b0;
                end
                if (stag_v) begin
                    sif.done_fe[stag_bit] = 1'b1;
                    stag_bit++;
                    if (stag_bit >= stag_len) stag_v = 1'b0;
                end
                if (reg_cnt > 0) begin
                    reg_cnt--;
                    if (reg_cnt == 0) sif.done_reg = reg_pend;
                end
                if (sif.start_fe != '0) begin
                    if (int'(sif.set_idx_fe) == fe_stagger_set) begin
                        stag_v   = 1'b1;
                        stag_bit = 0;
                        stag_len = $countones(sif.start_fe);
                    end else begin
                        fe_pend   = sif.start_fe;
                        fe_pend_v = 1'b1;
                    end
                end
                if (sif.start_reg != '0) begin
                    reg_pend = sif.start_reg;
                    reg_cnt  = (sif.set_idx_reg == '0) ? reg_delay0 : 1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    int   fe_mask_q[$], fe_idx_q[$], fe_cyc_q[$];
    int   reg_mask_q[$], reg_idx_q[$], reg_cyc_q[$];
    int   done_cyc_q[$], load_cyc_q[$], busy_rise_q[$], busy_fall_q[$];
    int   pulse_bad = 0;
    logic load_prev = 1'b0;
    logic busy_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (sif.start_fe != '0) begin
                fe_mask_q.push_back(int'(sif.start_fe));
                fe_idx_q.push_back(int'(sif.set_idx_fe));
                fe_cyc_q.push_back(cyc);
                if (sif.start_fe != sif.mask_fe) pulse_bad++;
            end
            if (sif.start_reg != '0) begin
                reg_mask_q.push_back(int'(sif.start_reg));
                reg_idx_q.push_back(int'(sif.set_idx_reg));
                reg_cyc_q.push_back(cyc);
                if (sif.start_reg != sif.mask_reg) pulse_bad++;
            end
            if (sif.frame_done === 1'b1) done_cyc_q.push_back(cyc);
            if (sif.load_req === 1'b1 && !load_prev) load_cyc_q.push_back(cyc);
            if (sif.frame_busy === 1'b1 && !busy_prev) busy_rise_q.push_back(cyc);
            if (sif.frame_busy === 1'b0 && busy_prev) busy_fall_q.push_back(cyc);
            load_prev = (sif.load_req === 1'b1);
            busy_prev = (sif.frame_busy === 1'b1);
        end
    end

    // ---------------------------------------------------------------- helpers
    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        fe_mask_q.delete();  fe_idx_q.delete();  fe_cyc_q.delete();
        reg_mask_q.delete(); reg_idx_q.delete(); reg_cyc_q.delete();
        done_cyc_q.delete(); load_cyc_q.delete();
        busy_rise_q.delete(); busy_fall_q.delete();
        pulse_bad = 0;
    endtask

    task automatic wait_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle start_frame; a is the cycle in which it is sampled.
    task automatic start_frame(input logic [BBOX_W-1:0] n, output int a);
        @(negedge clk);
        #1;
        clear_logs();
        sif.start_frame   = 1'b1;
        sif.num_of_bboxes = n;
        a = cyc;
        @(negedge clk);
        #1;
        sif.start_frame   = 1'b0;
        sif.num_of_bboxes = '0;
    endtask

    task automatic wait_frame_done(input string tag, input int budget);
        int i;
        i = 0;
        while (done_cyc_q.size() == 0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (done_cyc_q.size() == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        wait_cycles(4);
    endtask

    task automatic check_sets(input string tag, input int nsets, input int last_mask);
        check({tag, "_fe_sets"}, fe_mask_q.size(), nsets);
        check({tag, "_reg_sets"}, reg_mask_q.size(), nsets);
        check({tag, "_loads"}, load_cyc_q.size(), nsets);
        check({tag, "_frame_done_cnt"}, done_cyc_q.size(), 1);
        check({tag, "_pulse_vs_mask"}, pulse_bad, 0);
        for (int i = 0; i < nsets; i++) begin
            int exp_mask;
            exp_mask = (i == nsets - 1) ? last_mask : FULL_MASK;
            check($sformatf("%s_fe_mask%0d", tag, i), at(fe_mask_q, i), exp_mask);
            check($sformatf("%s_fe_idx%0d", tag, i), at(fe_idx_q, i), i);
            check($sformatf("%s_reg_mask%0d", tag, i), at(reg_mask_q, i), exp_mask);
            check($sformatf("%s_reg_idx%0d", tag, i), at(reg_idx_q, i), i);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        sif.frame_busy,  0);
        check({tag, "_done"},        sif.frame_done,  0);
        check({tag, "_load_req"},    sif.load_req,    0);
        check({tag, "_set_idx_fe"},  sif.set_idx_fe,  0);
        check({tag, "_mask_fe"},     sif.mask_fe,     0);
        check({tag, "_start_fe"},    sif.start_fe,    0);
        check({tag, "_set_idx_reg"}, sif.set_idx_reg, 0);
        check({tag, "_mask_reg"},    sif.mask_reg,    0);
        check({tag, "_start_reg"},   sif.start_reg,   0);
    endtask

    // ------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------ main
    initial begin
        int a;
        sif.start_frame   = 1'b0;
        sif.num_of_bboxes = '0;
        reset = 1'b1;
        wait_cycles(3);
        check_all_zero("reset");
        reset = 1'b0;
        wait_cycles(2);

        // n=70: sets of 24, 24, 22 with immediate acks and dones.
        start_frame(8'd70, a);
        wait_frame_done("n70", 100);
        check_sets("n70", 3, 32'h003F_FFFF);
        check("n70_busy_rise",  at(busy_rise_q, 0) - a, 1);
        check("n70_load_rise",  at(load_cyc_q, 0) - a, 1);
        check("n70_fe0_start",  at(fe_cyc_q, 0) - a, 2);
        check("n70_reg0_start", at(reg_cyc_q, 0) - a, 5);
        check("n70_load1",      at(load_cyc_q, 1) - a, 5);
        check("n70_done_at",    at(done_cyc_q, 0) - a, 15);
        check("n70_busy_fall",  at(busy_fall_q, 0) - a, 15);

        // n=48: two full sets.
        start_frame(8'd48, a);
        wait_frame_done("n48", 100);
        check_sets("n48", 2, FULL_MASK);
        check("n48_done_at", at(done_cyc_q, 0) - a, 11);

        // n=1: a single one-PE set.
        start_frame(8'd1, a);
        wait_frame_done("n1", 100);
        check_sets("n1", 1, 32'h0000_0001);
        check("n1_done_at", at(done_cyc_q, 0) - a, 7);

        // n=0: done the next cycle, no load and no starts.
        start_frame(8'd0, a);
        wait_frame_done("n0", 20);
        check("n0_done_at",   at(done_cyc_q, 0) - a, 1);
        check("n0_done_cnt",  done_cyc_q.size(), 1);
        check("n0_loads",     load_cyc_q.size(), 0);
        check("n0_fe_starts", fe_mask_q.size(), 0);
        check("n0_reg_starts", reg_mask_q.size(), 0);
        check("n0_busy",      busy_rise_q.size(), 0);

        // Overlap stall: set-0 registration takes 20 cycles, set 1 parks in
        // FE_HOLD and set 2 must not be loaded until set 1 is handed off.
        reg_delay0 = 20;
        start_frame(8'd70, a);
        wait_cycles(13);
        check("stall_mid_load_req", sif.load_req, 0);
        check("stall_mid_idx_fe",   sif.set_idx_fe, 1);
        check("stall_mid_reg_cnt",  reg_mask_q.size(), 1);
        wait_frame_done("stall", 150);
        check_sets("stall", 3, 32'h003F_FFFF);
        check("stall_reg1_after_reg0", at(reg_cyc_q, 1) - at(reg_cyc_q, 0), 22);
        check("stall_load2",   at(load_cyc_q, 2) - a, 27);
        check("stall_fe2",     at(fe_cyc_q, 2) - a, 28);
        check("stall_done_at", at(done_cyc_q, 0) - a, 33);
        reg_delay0 = 1;

        // Staggered set-2 dones with PEs 22/23 stuck high, plus a start_frame
        // while busy that must be ignored.
        fe_stagger_set = 2;
        fe_force       = 24'hC0_0000;
        start_frame(8'd70, a);
        wait_cycles(2);
        sif.start_frame   = 1'b1;
        sif.num_of_bboxes = 8'd5;
        wait_cycles(1);
        sif.start_frame   = 1'b0;
        sif.num_of_bboxes = '0;
        wait_frame_done("stag", 150);
        check_sets("stag", 3, 32'h003F_FFFF);
        check("stag_fe2_start",  at(fe_cyc_q, 2) - a, 10);
        check("stag_reg2_start", at(reg_cyc_q, 2) - a, 34);
        check("stag_done_at",    at(done_cyc_q, 0) - a, 36);
        fe_stagger_set = -1;
        fe_force       = '0;

        // Reset during set-1 FE, then a clean n=24 frame.
        start_frame(8'd70, a);
        wait_cycles(6);
        check("rst_pre_idx_fe", sif.set_idx_fe, 1);
        reset = 1'b1;
        wait_cycles(1);
        check_all_zero("midrst");
        reset = 1'b0;
        clear_logs();
        wait_cycles(10);
        check("midrst_no_done",  done_cyc_q.size(), 0);
        check("midrst_no_load",  load_cyc_q.size(), 0);
        check("midrst_no_start", fe_mask_q.size() + reg_mask_q.size(), 0);

        start_frame(8'd24, a);
        wait_frame_done("n24", 100);
        check_sets("n24", 1, FULL_MASK);
        check("n24_done_at", at(done_cyc_q, 0) - a, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
